// File: rtl/vx_dcache_responder_pkg.sv
// Shared constants for the dcache responder: default geometry, FSM encodings
// and the packed width of one response queue entry.
package vx_dcache_responder_pkg;

    localparam int DEF_NUM_REQS       = 4;
    localparam int DEF_WORD_SIZE      = 4;
    localparam int DEF_TAG_WIDTH      = 8;
    localparam int DEF_ADDR_WIDTH     = 30;
    localparam int DEF_NUM_ROWS       = 256;
    localparam int DEF_RSP_QUEUE_SIZE = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Entry layout, MSB first: {read mask, gathered lane data, lead read tag}
    function automatic int rsp_entry_width(input int num_reqs, input int word_size,
                                           input int tag_width);
        return num_reqs + num_reqs * word_size * 8 + tag_width;
    endfunction

endpackage

// File: rtl/vx_dcache_responder_queue.sv
// First-word-fall-through response queue; the head entry is always visible
// on data_out while the queue is not empty.
module vx_dcache_responder_queue #(
    parameter int DATAW = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             empty,
    output logic             full
);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DATAW-1:0] store [DEPTH];
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;
    logic [CNTW-1:0]  count;

    always_ff @(posedge clk) begin
        if (push)
            store[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTRW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTRW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign data_out = store[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CNTW'(DEPTH));

endmodule

// File: rtl/vx_dcache_responder.sv
// Banked scratchpad acting as a dcache slave: accepts one multi-lane batch at
// a time, serializes bank conflicts and returns one gathered read response.
//
// state    | meaning
// IDLE     | waiting for a batch; req_ready depends on queue room for reads
// SERVE    | each bank serves its lowest pending lane per cycle
// DRAIN    | last read lands in the gather buffer; response pushed if any read
module vx_dcache_responder
    import vx_dcache_responder_pkg::*;
#(
    parameter int NUM_REQS       = DEF_NUM_REQS,
    parameter int WORD_SIZE      = DEF_WORD_SIZE,
    parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int NUM_ROWS       = DEF_NUM_ROWS,
    parameter int RSP_QUEUE_SIZE = DEF_RSP_QUEUE_SIZE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid,
    input  logic [NUM_REQS-1:0]               req_rw,
    input  logic [NUM_REQS*WORD_SIZE-1:0]     req_byteen,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQS*WORD_SIZE*8-1:0]   req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]     req_tag,
    output logic [NUM_REQS-1:0]               req_ready,
    output logic                              rsp_valid,
    output logic [NUM_REQS-1:0]               rsp_tmask,
    output logic [NUM_REQS*WORD_SIZE*8-1:0]   rsp_data,
    output logic [TAG_WIDTH-1:0]              rsp_tag,
    input  logic                              rsp_ready
);
    localparam int BANK_BITS = $clog2(NUM_REQS);
    localparam int ROW_BITS  = $clog2(NUM_ROWS);
    localparam int IDX_BITS  = BANK_BITS + ROW_BITS;
    localparam int WORD_BITS = WORD_SIZE * 8;
    localparam int ENTRY_W   = rsp_entry_width(NUM_REQS, WORD_SIZE, TAG_WIDTH);

    logic [1:0]                               state;
    logic [NUM_REQS-1:0]                      pending, pending_next, cap_valid, cap_rw;
    logic [NUM_REQS-1:0][WORD_SIZE-1:0]       cap_byteen;
    logic [NUM_REQS-1:0][IDX_BITS-1:0]        cap_idx;
    logic [NUM_REQS-1:0][WORD_BITS-1:0]       cap_data, gather, gather_next, bank_rdata;
    logic [NUM_REQS-1:0][TAG_WIDTH-1:0]       cap_tag;
    logic [NUM_REQS-1:0]                      sel_valid, sel_read, served, rd_pend, read_mask;
    logic [NUM_REQS-1:0][BANK_BITS-1:0]       sel_lane, rd_lane;
    logic [TAG_WIDTH-1:0]                     lead_tag;
    logic                                     ready_int, fire, push, pop, q_full, q_empty;
    logic [ENTRY_W-1:0]                       q_in, q_out;
    logic                                     unused_addr_bits;

    // Reads need a free queue slot at accept time; write-only batches never push.
    assign ready_int = !reset && (state == ST_IDLE) && (!q_full || !(|(req_valid & ~req_rw)));
    assign req_ready = {NUM_REQS{ready_int}};
    assign fire      = ready_int && (|req_valid);

    always_comb begin
        unused_addr_bits = 1'b0;
        for (int i = 0; i < NUM_REQS; i++)
            unused_addr_bits ^= ^req_addr[i*ADDR_WIDTH+IDX_BITS +: ADDR_WIDTH-IDX_BITS];
    end

    // Lowest pending lane wins each bank; higher lanes wait for later cycles.
    always_comb begin
        sel_valid = '0;
        sel_read  = '0;
        sel_lane  = '0;
        served    = '0;
        for (int b = 0; b < NUM_REQS; b++) begin
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                if (pending[i] && (cap_idx[i][BANK_BITS-1:0] == BANK_BITS'(b))) begin
                    sel_valid[b] = 1'b1;
                    sel_lane[b]  = BANK_BITS'(i);
                end
            end
            if (sel_valid[b]) begin
                served[sel_lane[b]] = 1'b1;
                sel_read[b]         = !cap_rw[sel_lane[b]];
            end
        end
    end

    assign pending_next = pending & ~served;

    for (genvar b = 0; b < NUM_REQS; b++) begin : g_bank
        logic [WORD_BITS-1:0] mem [NUM_ROWS];
        logic [WORD_BITS-1:0] rdata_q;
        logic [BANK_BITS-1:0] lane;
        logic [ROW_BITS-1:0]  row;
        logic                 en;

        assign lane = sel_lane[b];
        assign row  = cap_idx[lane][BANK_BITS +: ROW_BITS];
        assign en   = (state == ST_SERVE) && sel_valid[b];

        always_ff @(posedge clk) begin
            if (en) begin
                if (cap_rw[lane]) begin
                    for (int k = 0; k < WORD_SIZE; k++)
                        if (cap_byteen[lane][k])
                            mem[row][k*8 +: 8] <= cap_data[lane][k*8 +: 8];
                end else begin
                    rdata_q <= mem[row];
                end
            end
        end

        assign bank_rdata[b] = rdata_q;
    end

    always_comb begin
        gather_next = gather;
        for (int b = 0; b < NUM_REQS; b++)
            if (rd_pend[b])
                gather_next[rd_lane[b]] = bank_rdata[b];
    end

    assign read_mask = cap_valid & ~cap_rw;

    always_comb begin
        lead_tag = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--)
            if (read_mask[i])
                lead_tag = cap_tag[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pending    <= '0;
            cap_valid  <= '0;
            cap_rw     <= '0;
            cap_byteen <= '0;
            cap_idx    <= '0;
            cap_data   <= '0;
            cap_tag    <= '0;
            gather     <= '0;
            rd_pend    <= '0;
            rd_lane    <= '0;
        end else begin
            rd_pend <= (state == ST_SERVE) ? sel_read : '0;
            rd_lane <= sel_lane;
            gather  <= (state == ST_DRAIN) ? '0 : gather_next;
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        pending    <= req_valid;
                        cap_valid  <= req_valid;
                        cap_rw     <= req_rw;
                        cap_byteen <= req_byteen;
                        cap_data   <= req_data;
                        cap_tag    <= req_tag;
                        for (int i = 0; i < NUM_REQS; i++)
                            cap_idx[i] <= req_addr[i*ADDR_WIDTH +: IDX_BITS];
                        state <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    pending <= pending_next;
                    if (pending_next == '0)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign push = (state == ST_DRAIN) && (|read_mask);
    assign pop  = !q_empty && rsp_ready;
    assign q_in = {read_mask, gather_next, lead_tag};

    vx_dcache_responder_queue #(
        .DATAW (ENTRY_W),
        .DEPTH (RSP_QUEUE_SIZE)
    ) u_rsp_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (q_in),
        .data_out (q_out),
        .empty    (q_empty),
        .full     (q_full)
    );

    // Queue storage is not reset, so the outputs are forced to zero when empty.
    assign rsp_valid = !q_empty;
    assign {rsp_tmask, rsp_data, rsp_tag} = q_empty ? '0 : q_out;

endmodule
